// File: rtl/omr_grader_seq_if.sv
// Handshake and result bundle between the bubble-sensing front end, the grader and the result logic.
// slave = grader side, master = front end / consumer side.
interface omr_grader_seq_if #(
  parameter int NUM_Q    = 10,
  parameter int NUM_OPT  = 4,
  parameter int POS_MARK = 4
);
  localparam int CNT_W   = $clog2(NUM_Q + 1);
  localparam int SCORE_W = $clog2(NUM_Q * POS_MARK + 1) + 1;

  logic                        key_load;
  logic [NUM_Q*NUM_OPT-1:0]    key_in;
  logic                        mode;
  logic                        sheet_start;
  logic                        sheet_abort;
  logic                        ans_valid;
  logic                        ans_ready;
  logic [NUM_OPT-1:0]          ans_data;
  logic                        result_valid;
  logic                        result_ready;
  logic [CNT_W-1:0]            num_correct;
  logic [CNT_W-1:0]            num_wrong;
  logic [CNT_W-1:0]            num_blank;
  logic [CNT_W-1:0]            num_multi;
  logic signed [SCORE_W-1:0]   score_out;
  logic [15:0]                 sheets_graded;
  logic                        busy;

  modport slave (
    input  key_load, key_in, mode, sheet_start, sheet_abort,
    input  ans_valid, ans_data, result_ready,
    output ans_ready, result_valid, num_correct, num_wrong, num_blank,
    output num_multi, score_out, sheets_graded, busy
  );

  modport master (
    output key_load, key_in, mode, sheet_start, sheet_abort,
    output ans_valid, ans_data, result_ready,
    input  ans_ready, result_valid, num_correct, num_wrong, num_blank,
    input  num_multi, score_out, sheets_graded, busy
  );
endinterface

// File: rtl/omr_grader_seq.sv
// Sequential OMR grader: one answer per accepted beat, classified and scored against a latched key.
// Results are held behind result_valid until result_ready; ans_ready is high only while grading.
module omr_grader_seq #(
  parameter int NUM_Q     = 10,
  parameter int NUM_OPT   = 4,
  parameter int POS_MARK  = 4,
  parameter int NEG_MARK  = 1,
  parameter int CLAMP_NEG = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  omr_grader_seq_if.slave      bus
);
  localparam int CNT_W   = $clog2(NUM_Q + 1);
  localparam int SCORE_W = $clog2(NUM_Q * POS_MARK + 1) + 1;
  localparam int IDX_W   = $clog2(NUM_Q);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRADE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [SCORE_W-1:0] POS_D = SCORE_W'(POS_MARK);
  localparam logic signed [SCORE_W-1:0] NEG_D = SCORE_W'(0) - SCORE_W'(NEG_MARK);
  localparam logic signed [SCORE_W-1:0] ONE_D = SCORE_W'(1);

  logic [1:0]                  r_state;
  logic [NUM_Q*NUM_OPT-1:0]    r_key;
  logic                        r_mode;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_num_correct;
  logic [CNT_W-1:0]            r_num_wrong;
  logic [CNT_W-1:0]            r_num_blank;
  logic [CNT_W-1:0]            r_num_multi;
  logic signed [SCORE_W-1:0]   r_acc;
  logic [15:0]                 r_sheets;

  logic [NUM_OPT-1:0]          w_key_q;
  logic                        w_dropped;
  logic                        w_blank;
  logic                        w_multi;
  logic                        w_correct;
  logic                        w_wrong;
  logic signed [SCORE_W-1:0]   w_delta;

  assign w_key_q   = r_key[r_idx*NUM_OPT +: NUM_OPT];
  assign w_dropped = (w_key_q == '0);
  assign w_blank   = !w_dropped && (bus.ans_data == '0);
  // x & (x-1) is non-zero exactly when more than one bubble is marked
  assign w_multi   = !w_dropped && (bus.ans_data != '0) &&
                     ((bus.ans_data & (bus.ans_data - NUM_OPT'(1))) != '0);
  assign w_correct = w_dropped || (!w_blank && !w_multi && (bus.ans_data == w_key_q));
  assign w_wrong   = !w_correct && !w_blank && !w_multi;

  always_comb begin
    w_delta = '0;
    if (r_mode) begin
      if (w_correct)
        w_delta = POS_D;
      else if (w_wrong || w_multi)
        w_delta = NEG_D;
    end else if (w_correct) begin
      w_delta = ONE_D;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_key         <= '0;
      r_mode        <= 1'b0;
      r_idx         <= '0;
      r_num_correct <= '0;
      r_num_wrong   <= '0;
      r_num_blank   <= '0;
      r_num_multi   <= '0;
      r_acc         <= '0;
      r_sheets      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.key_load)
            r_key <= bus.key_in;
          if (bus.sheet_start) begin
            r_num_correct <= '0;
            r_num_wrong   <= '0;
            r_num_blank   <= '0;
            r_num_multi   <= '0;
            r_acc         <= '0;
            r_idx         <= '0;
            r_mode        <= bus.mode;
            r_state       <= S_GRADE;
          end
        end
        S_GRADE: begin
          if (bus.sheet_abort) begin
            r_state <= S_IDLE;
          end else if (bus.ans_valid) begin
            r_num_correct <= r_num_correct + CNT_W'(w_correct);
            r_num_wrong   <= r_num_wrong   + CNT_W'(w_wrong);
            r_num_blank   <= r_num_blank   + CNT_W'(w_blank);
            r_num_multi   <= r_num_multi   + CNT_W'(w_multi);
            r_acc         <= r_acc + w_delta;
            r_idx         <= r_idx + IDX_W'(1);
            if (r_idx == IDX_W'(NUM_Q - 1))
              r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.result_ready) begin
            r_sheets <= r_sheets + 16'd1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ans_ready     = (r_state == S_GRADE);
  assign bus.result_valid  = (r_state == S_DONE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.num_correct   = r_num_correct;
  assign bus.num_wrong     = r_num_wrong;
  assign bus.num_blank     = r_num_blank;
  assign bus.num_multi     = r_num_multi;
  assign bus.sheets_graded = r_sheets;
  assign bus.score_out     = ((CLAMP_NEG != 0) && r_acc[SCORE_W-1]) ? '0 : r_acc;
endmodule
